parking_gate_scheduler: RTL
===========================

Name: parking_gate_scheduler

Overview:
Sequences car events from NUM_GATES physical gates into the parking occupancy block, which is edge-triggered on its car_entered / car_exited strobes.
- Round-robin arbitration between gates.
- Pre-checks entry admission against the occupancy block's vacancy flags and the opening hour.
- Emits one clean, spaced strobe per admitted event.
- Returns a done/ok handshake to the requesting gate.

Parameters:
NUM_GATES, 4, number of gate requesters (2..8)
STROBE_CYC, 2, cycles each event strobe is held high (>=1)
GAP_CYC, 2, cycles strobes are held low after a strobe before the next event (>=1)
OPEN_HOUR, 8, first hour (inclusive) in which events are processed

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
current_hour  in  5  hour of day 0..23
uni_is_vacated_space  in  1  vacancy flag from occupancy block, uni zone
is_vacated_space  in  1  vacancy flag from occupancy block, free zone
gate_req  in  NUM_GATES  per-gate request; held high until that gate's gate_done
gate_dir  in  NUM_GATES  per-gate direction: 1 = entry, 0 = exit; stable while req high
gate_uni  in  NUM_GATES  per-gate car class: 1 = uni car; stable while req high
gate_done  out  NUM_GATES  one-hot, 1-cycle pulse completing the winner's request
gate_ok  out  1  valid with gate_done: 1 = admitted/processed, 0 = rejected
car_entered  out  1  entry strobe to occupancy block
is_uni_car_entered  out  1  class of entering car; stable for the whole strobe
car_exited  out  1  exit strobe to occupancy block
is_uni_car_exited  out  1  class of exiting car; stable for the whole strobe
busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs registered. Reset value of every output is 0. Reset state is IDLE; RR pointer resets to 0.
- FSM states: IDLE, STROBE, GAP, DONE.
- IDLE:
  - If any gate_req is set, pick the winner: the first requesting gate at or after the RR pointer, wrapping modulo NUM_GATES.
  - Latch the winner's index, dir and uni. Set the pointer to (winner+1) mod NUM_GATES.
  - Latch accept:
    - current_hour < OPEN_HOUR -> accept = 0.
    - Entry, uni car -> accept = uni_is_vacated_space | is_vacated_space.
    - Entry, non-uni car -> accept = is_vacated_space.
    - Exit -> accept = 1.
  - Transition: accept -> STROBE; otherwise -> DONE.
- STROBE: drive car_entered (dir = 1) or car_exited (dir = 0) high for exactly STROBE_CYC cycles. The matching is_uni_* output equals the latched uni from the first strobe cycle through the end of GAP. Then -> GAP.
- GAP: both strobes low for GAP_CYC cycles. Then -> DONE.
- DONE: gate_done[winner] = 1 and gate_ok = latched accept, for 1 cycle. Then -> IDLE.
- Latency from first req-high cycle to gate_done:
  - Accepted: 2 + STROBE_CYC + GAP_CYC cycles (defaults: 6).
  - Rejected: 2 cycles.
- Gate contract: the gate deasserts req in the cycle after gate_done. Scheduler protection: in the first IDLE cycle after DONE, the previous winner's request is masked.
- Only one event is in flight at a time. The occupancy block remains authoritative. Vacancy flags are sampled once, in the IDLE decision cycle, and are not rechecked.
- Simultaneous requests are served in RR order; no gate waits more than NUM_GATES-1 other events.
- A req that drops before its gate_done is a protocol error. The scheduler still completes the latched event.
- Reset asserted mid-event: strobes go low in the next cycle, the FSM returns to IDLE, and no gate_done is issued.
- Stall counters are width clog2(max(STROBE_CYC, GAP_CYC)+1) and reload on state entry.

Optional Feature:
PARK_SCHED_STATS_EN
- Defined:
  - Adds output reject_cnt[15:0], counting DONE cycles with gate_ok = 0.
  - Adds output served_cnt[15:0], counting DONE cycles with gate_ok = 1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic are absent; core timing is identical.

Decomposition:
- Package parking_pkg:
  - FSM state enum.
  - Direction constants DIR_EXIT = 0, DIR_ENTRY = 1.
  - Default OPEN_HOUR.
  - Zone capacity constants, shared with the occupancy block: UNI_CAP_AM = 500, FREE_CAP_AM = 200, TOTAL_CAP = 700.
- Sub-module parking_rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, pointer, mask.
  - Outputs: winner index, any_req.
- The scheduler instantiates it and owns the FSM, the latches and the stall counters.

Test Plan:
- Reset: hold rst 3 cycles with gate_req = 4'b1111 -> all outputs 0, busy 0; first grant goes to gate 0 after release.
- Single uni entry: hour = 9, both vacancy flags 1, gate 2 entry uni.
  - car_entered high for 2 cycles with is_uni_car_entered = 1.
  - gate_done = 4'b0100 and gate_ok = 1 exactly 6 cycles after req.
- Rejections:
  - hour = 7, gate 1 entry -> no strobe; gate_done[1] with gate_ok = 0 after 2 cycles.
  - hour = 14, is_vacated_space = 0, non-uni entry -> same reject.
- Uni overflow: uni_is_vacated_space = 0, is_vacated_space = 1, uni entry -> accepted, car_entered pulses.
- Fairness: gate_req = 4'b1111 held, with each gate dropping req after its done -> service order 0,1,2,3; exits drive car_exited only; strobes separated by >=2 low cycles.
- Mid-event reset: assert rst during the 2nd STROBE cycle -> car_entered low next cycle, no gate_done, FSM returns to IDLE.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate scheduler and the
// occupancy block it feeds.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  localparam logic DIR_EXIT  = 1'b0;
  localparam logic DIR_ENTRY = 1'b1;

  localparam int DEFAULT_OPEN_HOUR = 8;

  // Zone capacities must match the occupancy block's own constants.
  localparam int UNI_CAP_AM  = 500;
  localparam int FREE_CAP_AM = 200;
  localparam int TOTAL_CAP   = 700;

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Gate-side request/completion bundle between the physical gates and the
// scheduler.
interface parking_gate_scheduler_if #(
  parameter int NUM_GATES = 4
);
  // Handshake: gate_req[i] is the valid and stays high (with gate_dir[i] and
  // gate_uni[i] stable) until the one-cycle gate_done[i]; gate_ok qualifies
  // that done pulse. The gate drops gate_req[i] in the following cycle.
  logic [NUM_GATES-1:0] gate_req;
  logic [NUM_GATES-1:0] gate_dir;
  logic [NUM_GATES-1:0] gate_uni;
  logic [NUM_GATES-1:0] gate_done;
  logic                 gate_ok;

  modport master (
    output gate_req, gate_dir, gate_uni,
    input  gate_done, gate_ok
  );

  modport slave (
    input  gate_req, gate_dir, gate_uni,
    output gate_done, gate_ok
  );
endinterface

// File: rtl/parking_rr_arbiter.sv
// Combinational round-robin pick: first unmasked requester at or after ptr,
// wrapping modulo NUM_GATES.
module parking_rr_arbiter
  import parking_pkg::*;
#(
  parameter int NUM_GATES = 4,
  parameter int PW        = 2
) (
  input  logic [NUM_GATES-1:0] req,
  input  logic [PW-1:0]        ptr,
  input  logic [NUM_GATES-1:0] mask,
  output logic [PW-1:0]        winner,
  output logic                 any_req
);

  logic [NUM_GATES-1:0] eff;
  logic [PW-1:0]        idx;
  int                   sum;

  assign eff = req & ~mask;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    sum     = 0;
    for (int i = 0; i < NUM_GATES; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_GATES) sum = sum - NUM_GATES;
      idx = PW'(sum);
      if (!any_req && eff[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Serialises gate car events into spaced entry/exit strobes for the occupancy
// block. Optional counters enabled by defining PARK_SCHED_STATS_EN.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_GATES  = 4,
  parameter int STROBE_CYC = 2,
  parameter int GAP_CYC    = 2,
  parameter int OPEN_HOUR  = DEFAULT_OPEN_HOUR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               current_hour,
  input  logic                     uni_is_vacated_space,
  input  logic                     is_vacated_space,
  parking_gate_scheduler_if.slave  gates,
  output logic                     car_entered,
  output logic                     is_uni_car_entered,
  output logic                     car_exited,
  output logic                     is_uni_car_exited,
  output logic                     busy,
`ifdef PARK_SCHED_STATS_EN
  output logic [15:0]              reject_cnt,
  output logic [15:0]              served_cnt,
`endif
  output sched_state_t             dbg_state
);

  localparam int PW   = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int MAXC = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [4:0] OPEN_H = 5'(OPEN_HOUR);

  sched_state_t         state;
  logic [CW-1:0]        cnt;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        win_idx;
  logic                 win_dir;
  logic                 win_uni;
  logic                 accept_q;
  logic                 mask_prev;
  logic [PW-1:0]        pick;
  logic                 any_req;
  logic                 accept_next;
  logic [NUM_GATES-1:0] win_onehot;
  logic [NUM_GATES-1:0] mask_vec;

  assign dbg_state  = state;
  assign win_onehot = {{(NUM_GATES-1){1'b0}}, 1'b1} << win_idx;
  // The last winner may still hold req in the IDLE cycle right after DONE.
  assign mask_vec   = mask_prev ? win_onehot : '0;

  parking_rr_arbiter #(.NUM_GATES(NUM_GATES), .PW(PW)) u_arb (
    .req     (gates.gate_req),
    .ptr     (ptr),
    .mask    (mask_vec),
    .winner  (pick),
    .any_req (any_req)
  );

  always_comb begin
    accept_next = 1'b1;
    if (current_hour < OPEN_H)
      accept_next = 1'b0;
    else if (gates.gate_dir[pick] == DIR_ENTRY)
      accept_next = gates.gate_uni[pick] ? (uni_is_vacated_space | is_vacated_space)
                                         : is_vacated_space;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      ptr                <= '0;
      win_idx            <= '0;
      win_dir            <= 1'b0;
      win_uni            <= 1'b0;
      accept_q           <= 1'b0;
      mask_prev          <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      gates.gate_done    <= '0;
      gates.gate_ok      <= 1'b0;
      busy               <= 1'b0;
    end else begin
      // Outputs are registered copies of the state held this cycle.
      car_entered        <= (state == STROBE) && win_dir;
      car_exited         <= (state == STROBE) && !win_dir;
      is_uni_car_entered <= ((state == STROBE) || (state == GAP)) && win_dir && win_uni;
      is_uni_car_exited  <= ((state == STROBE) || (state == GAP)) && !win_dir && win_uni;
      gates.gate_done    <= (state == DONE) ? win_onehot : '0;
      gates.gate_ok      <= (state == DONE) && accept_q;
      busy               <= (state != IDLE);

      case (state)
        IDLE: begin
          mask_prev <= 1'b0;
          if (any_req) begin
            win_idx  <= pick;
            win_dir  <= gates.gate_dir[pick];
            win_uni  <= gates.gate_uni[pick];
            accept_q <= accept_next;
            ptr      <= (pick == PW'(NUM_GATES - 1)) ? '0 : pick + 1'b1;
            if (accept_next) begin
              state <= STROBE;
              cnt   <= CW'(STROBE_CYC - 1);
            end else begin
              state <= DONE;
            end
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= CW'(GAP_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          mask_prev <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PARK_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      reject_cnt <= '0;
      served_cnt <= '0;
    end else if (state == DONE) begin
      if (accept_q && (served_cnt != 16'hFFFF)) served_cnt <= served_cnt + 16'd1;
      if (!accept_q && (reject_cnt != 16'hFFFF)) reject_cnt <= reject_cnt + 16'd1;
    end
  end
`endif

endmodule
